// File: rtl/shape_cfg_scheduler_pkg.sv
// Shared types, field positions and legality rules for the shape processor
// configuration path; also used by the bench reference model.
package shape_cfg_pkg;

  typedef logic [1:0] shape_t;
  typedef logic [4:0] operation_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_ILLEGAL  = 2'd1,
    ST_MISMATCH = 2'd2,
    ST_PROC_ERR = 2'd3
  } status_e;

  localparam int unsigned SHAPE_LSB = 16;
  localparam int unsigned OP_LSB    = 0;

  function automatic logic is_legal_shape(shape_t s);
    return (s == 2'b01) || (s == 2'b10);
  endfunction

  function automatic logic is_legal_operation(operation_t op);
    logic ok;
    ok = 1'b0;
    case (op[4:3])
      2'b00:   ok = (op[2:0] <= 3'd1);
      2'b01:   ok = (op[2:0] == 3'd0);
      2'b10:   ok = (op[2:0] <= 3'd1);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_legal_combination(shape_t s, operation_t op);
    return (op[4:3] == 2'b00) || (op[4:3] == s);
  endfunction

endpackage

// File: rtl/shape_cfg_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after the
// pointer; the pointer moves past the winner when advance is asserted.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int unsigned      k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(ptr_q) + i;
      if (k >= NUM_REQ) begin
        k = k - NUM_REQ;
      end
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/shape_cfg_scheduler.sv
// Arbitrates requesters onto the shape processor SFR port: legality check,
// write, read-back compare and a one-cycle status response per command.
module shape_cfg_scheduler
  import shape_cfg_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][1:0] req_shape,
  input  logic [NUM_REQ-1:0][4:0] req_op,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [1:0]              rsp_status,
  output logic                    sp_write,
  output logic [31:0]             sp_write_data,
  output logic                    sp_read,
  input  logic [31:0]             sp_read_data,
  input  logic                    sp_error
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WRITE, S_READ, S_WAIT_RD, S_COMPARE, S_RESP
  } state_e;

  state_e           state;
  logic [IDX_W-1:0] g_q;
  shape_t           shape_q;
  operation_t       op_q;
  status_e          status_q;
  logic             err_q;
  logic [1:0]       cnt_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               grant_now;
  logic               legal;
  logic               mismatch;
  logic [NUM_REQ-1:0] rsp_onehot;
  logic [31:0]        wdata;
  logic               unused_rd_bits;

  assign grant_now = (state == S_IDLE) && (|req_valid);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (grant_now),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  assign legal = is_legal_shape(shape_q) && is_legal_operation(op_q)
              && is_legal_combination(shape_q, op_q);

  assign mismatch = (sp_read_data[SHAPE_LSB +: 2] != shape_q)
                 || (sp_read_data[OP_LSB +: 5] != op_q);

  assign unused_rd_bits = ^{sp_read_data[31:18], sp_read_data[15:5]};

  // Read data is valid RD_LAT cycles after READ, i.e. in COMPARE; WAIT_RD
  // covers the RD_LAT-1 cycles in between and is bypassed when RD_LAT is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      g_q      <= '0;
      shape_q  <= '0;
      op_q     <= '0;
      status_q <= ST_OK;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (sp_error && (state inside {S_WRITE, S_READ, S_WAIT_RD})) begin
        err_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (grant_now) begin
            g_q     <= gnt_idx;
            shape_q <= req_shape[gnt_idx];
            op_q    <= req_op[gnt_idx];
            err_q   <= 1'b0;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (legal) begin
            state <= S_WRITE;
          end else begin
            status_q <= ST_ILLEGAL;
            state    <= S_RESP;
          end
        end
        S_WRITE: state <= S_READ;
        S_READ: begin
          cnt_q <= 2'(RD_LAT - 1);
          state <= (RD_LAT > 1) ? S_WAIT_RD : S_COMPARE;
        end
        S_WAIT_RD: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (err_q) begin
            status_q <= ST_PROC_ERR;
          end else if (mismatch) begin
            status_q <= ST_MISMATCH;
          end else begin
            status_q <= ST_OK;
          end
          state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_onehot      = '0;
    rsp_onehot[g_q] = 1'b1;
    wdata                  = '0;
    wdata[SHAPE_LSB +: 2]  = shape_q;
    wdata[OP_LSB +: 5]     = op_q;
  end

  assign req_ready     = (grant_now && !rst) ? gnt : '0;
  assign rsp_valid     = (state == S_RESP) ? rsp_onehot : '0;
  assign rsp_status    = (state == S_RESP) ? status_q : ST_OK;
  assign sp_write      = (state == S_WRITE);
  assign sp_write_data = (state == S_WRITE) ? wdata : '0;
  assign sp_read       = (state == S_READ);

endmodule
